// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: RAM geometry defaults and the RAM-arbiter state encoding.
package sap1_pkg;

  localparam int SAP1_ADDR_W = 4;
  localparam int SAP1_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PENDING = 2'b01,
    ST_WRITE   = 2'b10
  } arb_state_t;

endpackage

// File: rtl/sap1_starve_counter.sv
// Wait counter for a loader write held off by the CPU; flags the cycle the write must be forced.
module sap1_starve_counter #(
  parameter int STARVE_LIMIT = 6
) (
  input  logic CLK,
  input  logic CLR,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'((STARVE_LIMIT > 0) ? STARVE_LIMIT - 1 : 0);

  logic [CW-1:0] wait_cnt;

  always_ff @(negedge CLK or negedge CLR) begin
    if (!CLR) begin
      wait_cnt <= '0;
    end else if (clr) begin
      wait_cnt <= '0;
    end else if (inc) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // A zero limit means the write is never deferred.
  assign at_limit = (STARVE_LIMIT == 0) || (wait_cnt == LAST);

endmodule

// File: rtl/sap1_ram_arbiter.sv
// Shares the SAP-1 RAM between the CPU and a program loader; CPU first, loader forced after a bounded wait.
//
// state   | meaning
// IDLE    | loader ready; CPU owns the RAM
// PENDING | loader write latched, waiting for a free cycle or the starvation limit
// WRITE   | one-cycle loader write; CPU stalled if it wanted the RAM
module sap1_ram_arbiter
  import sap1_pkg::*;
#(
  parameter int ADDR_W       = SAP1_ADDR_W,
  parameter int DATA_W       = SAP1_DATA_W,
  parameter int STARVE_LIMIT = 6
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              ldr_valid,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_data,
  output logic              ldr_ready,
  output logic              ldr_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_oe,
  output logic              cpu_stall,
  output logic [ADDR_W:0]   wr_count,
  output logic              load_full
);

  localparam logic [ADDR_W:0] WR_FULL = {1'b1, {ADDR_W{1'b0}}};

  arb_state_t        state, state_nxt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic              accept;
  logic              in_write;
  logic              cnt_inc;
  logic              at_limit;

  assign accept   = (state == ST_IDLE) && ldr_valid;
  assign in_write = (state == ST_WRITE);

  sap1_starve_counter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .CLK     (CLK),
    .CLR     (CLR),
    .clr     (accept),
    .inc     (cnt_inc),
    .at_limit(at_limit)
  );

  always_comb begin
    state_nxt = state;
    cnt_inc   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ldr_valid) begin
          state_nxt = (!cpu_req || STARVE_LIMIT == 0) ? ST_WRITE : ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (!cpu_req || at_limit) begin
          state_nxt = ST_WRITE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_WRITE: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(negedge CLK or negedge CLR) begin
    if (!CLR) begin
      state    <= ST_IDLE;
      lat_addr <= '0;
      lat_data <= '0;
      wr_count <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        lat_addr <= ldr_addr;
        lat_data <= ldr_data;
      end
      if (in_write && wr_count != WR_FULL) begin
        wr_count <= wr_count + 1'b1;
      end
    end
  end

  // Everything loader-facing is gated by state, so a reset mid-write cannot leave ram_we high.
  assign ldr_ready = (state == ST_IDLE);
  assign ldr_done  = in_write;
  assign ram_we    = in_write;
  assign ram_oe    = cpu_req && !in_write;
  assign cpu_stall = cpu_req && in_write;
  assign ram_addr  = in_write ? lat_addr : cpu_addr;
  assign ram_wdata = in_write ? lat_data : '0;
  assign load_full = (wr_count == WR_FULL);

endmodule
